// File: rtl/arb_mux8way16_pkg.sv
// Shared types and the rotate-and-priority pick used by the round-robin arbiter.
// Pure combinational helpers, no state.
package arb_pkg;

  localparam int NREQ_MAX = 8;
  localparam int SELW_MAX = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  // First set bit of req searching upward from last+1, wrapping at nreq-1.
  function automatic logic [SELW_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                                   input logic [SELW_MAX-1:0] last,
                                                   input int nreq);
    logic [SELW_MAX-1:0] win;
    logic found;
    int idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ_MAX; i++) begin
      idx = int'(last) + i;
      if (idx >= nreq) idx = idx - nreq;
      if (i <= nreq && !found && req[idx[SELW_MAX-1:0]]) begin
        win   = idx[SELW_MAX-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/arb_mux8way16_if.sv
// Requester/consumer bus of the arbiter; slave modport is the arbiter side.
// o/o_valid/o_ready form a valid-ready handshake, ack pulses on consumption.
interface arb_mux8way16_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 8
);
  localparam int SELW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      o;
  logic                  o_valid;
  logic                  o_ready;
  logic [SELW-1:0]       sel;
  logic                  busy;

  modport slave  (input req, data, o_ready, output ack, o, o_valid, sel, busy);
  modport master (output req, data, o_ready, input ack, o, o_valid, sel, busy);

endinterface

// File: rtl/arb_mux8way16_prims.sv
// Word mux and one-of-N decode primitives; purely combinational, no backpressure.
// DMux outputs are MSB-first: sel=k drives o[N-1-k].
module Mux4Way16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);
  always_comb begin
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end
endmodule

module Mux8Way16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic [W-1:0] f,
  input  logic [W-1:0] g,
  input  logic [W-1:0] h,
  input  logic [2:0]   sel,
  output logic [W-1:0] out
);
  logic [W-1:0] lo, hi;

  Mux4Way16 #(.W(W)) u_lo (.a(a), .b(b), .c(c), .d(d), .sel(sel[1:0]), .out(lo));
  Mux4Way16 #(.W(W)) u_hi (.a(e), .b(f), .c(g), .d(h), .sel(sel[1:0]), .out(hi));

  assign out = sel[2] ? hi : lo;
endmodule

module DMux4Way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic [3:0] o
);
  always_comb begin
    o = '0;
    o[2'd3 - sel] = in;
  end
endmodule

module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] o
);
  always_comb begin
    o = '0;
    o[3'd7 - sel] = in;
  end
endmodule

// File: rtl/arb_mux8way16_rr_pick.sv
// Combinational winner select from (req, last); ARB_FIXED_PRIO_EN makes index 0 always win.
// Zero latency, no handshake.
module rr_pick_comb
  import arb_pkg::*;
#(
  parameter int NREQ = 8,
  parameter int SELW = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] winner,
  output logic            any
);
  logic [NREQ_MAX-1:0] req_ext;
  logic [SELW_MAX-1:0] last_ext;
  logic [SELW_MAX-1:0] pick;

  assign req_ext = NREQ_MAX'(req);

`ifdef ARB_FIXED_PRIO_EN
  // Pretending the top index won last makes the search start at bit 0.
  logic unused_last;
  assign unused_last = ^last;
  assign last_ext    = SELW_MAX'(NREQ - 1);
`else
  assign last_ext = SELW_MAX'(last);
`endif

  assign pick   = rr_pick(req_ext, last_ext, NREQ);
  assign winner = SELW'(pick);
  assign any    = |req;
endmodule

// File: rtl/arb_mux8way16.sv
// Round-robin arbiter (fixed priority with ARB_FIXED_PRIO_EN) sharing one registered word output.
// req->o_valid one cycle; o held under !o_ready; ack pulses combinationally on the handshake.
module arb_mux8way16
  import arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 8
) (
  input  logic              clk,
  input  logic              reset,
  arb_mux8way16_if.slave    bus
);
  localparam int SELW = $clog2(NREQ);
  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_GRANT = 1'(GRANT);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  last_q, last_d;

  logic [SELW-1:0]  winner;
  logic             any;
  logic [WIDTH-1:0] mux_out;
  logic             hs;
  logic [NREQ-1:0]  dmux_o;

  rr_pick_comb #(.NREQ(NREQ), .SELW(SELW)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  assign hs = (state_q == ST_GRANT) && o_valid_q && bus.o_ready;

  generate
    if (NREQ == 8) begin : g_n8
      Mux8Way16 #(.W(WIDTH)) u_mux (
        .a(bus.data[0*WIDTH +: WIDTH]), .b(bus.data[1*WIDTH +: WIDTH]),
        .c(bus.data[2*WIDTH +: WIDTH]), .d(bus.data[3*WIDTH +: WIDTH]),
        .e(bus.data[4*WIDTH +: WIDTH]), .f(bus.data[5*WIDTH +: WIDTH]),
        .g(bus.data[6*WIDTH +: WIDTH]), .h(bus.data[7*WIDTH +: WIDTH]),
        .sel(winner), .out(mux_out)
      );
      DMux8Way u_dmux (.in(hs), .sel(sel_q), .o(dmux_o));
    end else if (NREQ == 4) begin : g_n4
      Mux4Way16 #(.W(WIDTH)) u_mux (
        .a(bus.data[0*WIDTH +: WIDTH]), .b(bus.data[1*WIDTH +: WIDTH]),
        .c(bus.data[2*WIDTH +: WIDTH]), .d(bus.data[3*WIDTH +: WIDTH]),
        .sel(winner), .out(mux_out)
      );
      DMux4Way u_dmux (.in(hs), .sel(sel_q), .o(dmux_o));
    end else begin : g_bad_nreq
      $error("arb_mux8way16: NREQ must be 4 or 8");
      assign mux_out = '0;
      assign dmux_o  = '0;
    end
  endgenerate

  // Decode primitive is MSB-first; flip so ack[k] belongs to requester k.
  for (genvar k = 0; k < NREQ; k++) begin : g_ack
    assign bus.ack[k] = dmux_o[NREQ-1-k];
  end

  always_comb begin
    state_d   = state_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    sel_d     = sel_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d   = ST_GRANT;
          sel_d     = winner;
          last_d    = winner;
          o_d       = mux_out;
          o_valid_d = 1'b1;
        end
      end
      default: begin
        if (hs) begin
          state_d   = ST_IDLE;
          o_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      sel_q     <= '0;
      last_q    <= SELW'(NREQ - 1);
    end else begin
      state_q   <= state_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_arb_mux8way16.sv
// Directed bench for arb_mux8way16 (NREQ=8 and NREQ=4 instances) with a grant scoreboard.
module tb_arb_mux8way16;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arb_mux8way16_if #(.WIDTH(16), .NREQ(8)) bus8();
  arb_mux8way16_if #(.WIDTH(16), .NREQ(4)) bus4();

  arb_mux8way16 #(.WIDTH(16), .NREQ(8)) dut  (.clk(clk), .reset(reset), .bus(bus8));
  arb_mux8way16 #(.WIDTH(16), .NREQ(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  exp_t sb8[$];
  exp_t sb4[$];
  exp_t e8, e4;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int w);
    exp_t e;
    e.sel  = 3'(s);
    e.word = 16'(w);
    return e;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb8.size() != 0 || sb4.size() != 0) && n < 80) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    assert (sb8.size() == 0 && sb4.size() == 0) else begin
      bad++;
      $error("FAIL %s_drain observed pending=%0d expected=0", tag, sb8.size() + sb4.size());
    end
    sb8.delete();
    sb4.delete();
  endtask

  // Scoreboard side: every handshake must match the oldest expected grant.
  always @(negedge clk) begin
    if (reset == 1'b0) begin
      if (bus8.o_valid && bus8.o_ready) begin
        total++;
        assert (sb8.size() != 0) else begin
          bad++;
          $error("FAIL hs8_unexpected observed sel=%0d expected=no grant", bus8.sel);
        end
        if (sb8.size() != 0) begin
          e8 = sb8.pop_front();
          chk("hs8_sel", 32'(bus8.sel), 32'(e8.sel));
          chk("hs8_o", 32'(bus8.o), 32'(e8.word));
          chk("hs8_ack", 32'(bus8.ack), 32'(8'(1) << e8.sel));
        end
      end else begin
        chk("ack8_quiet", 32'(bus8.ack), 32'd0);
      end
      if (bus4.o_valid && bus4.o_ready) begin
        total++;
        assert (sb4.size() != 0) else begin
          bad++;
          $error("FAIL hs4_unexpected observed sel=%0d expected=no grant", bus4.sel);
        end
        if (sb4.size() != 0) begin
          e4 = sb4.pop_front();
          chk("hs4_sel", 32'(bus4.sel), 32'(e4.sel));
          chk("hs4_o", 32'(bus4.o), 32'(e4.word));
          chk("hs4_ack", 32'(bus4.ack), 32'(4'(1) << e4.sel));
        end
      end else begin
        chk("ack4_quiet", 32'(bus4.ack), 32'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.req = '0;
    bus8.o_ready = 1'b0;
    bus4.req = '0;
    bus4.o_ready = 1'b0;
    for (int k = 0; k < 8; k++) bus8.data[k*16 +: 16] = 16'(k + 1);
    for (int k = 0; k < 4; k++) bus4.data[k*16 +: 16] = 16'(k + 1);

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_o_valid", 32'(bus8.o_valid), 32'd0);
    chk("rst_o", 32'(bus8.o), 32'd0);
    chk("rst_ack", 32'(bus8.ack), 32'd0);
    chk("rst_sel", 32'(bus8.sel), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst4_o_valid", 32'(bus4.o_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset while granted and stalled.
    bus8.req = 8'b0000_0100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy", 32'(bus8.busy), 32'd1);
    chk("mid_o", 32'(bus8.o), 32'd3);
    chk("mid_sel", 32'(bus8.sel), 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    bus8.req = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_o_valid", 32'(bus8.o_valid), 32'd0);
    chk("mid_rst_ack", 32'(bus8.ack), 32'd0);
    chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus8.req = 8'b0000_0101;
    bus8.o_ready = 1'b1;
    sb8.push_back(mk(0, 1));
    drain("mid_first");
    bus8.req = 8'b0000_0100;
    sb8.push_back(mk(2, 3));
    drain("mid_second");
    bus8.req = '0;

    // Single requester: latency and one-cycle ack.
    bus8.req = 8'b0010_0000;
    sb8.push_back(mk(5, 6));
    @(negedge clk);
    chk("single_lat_n", 32'(bus8.o_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(bus8.o_valid), 32'd1);
    chk("single_o", 32'(bus8.o), 32'd6);
    chk("single_sel", 32'(bus8.sel), 32'd5);
    chk("single_ack", 32'(bus8.ack), 32'h20);
    @(posedge clk); #1;
    bus8.req = '0;
    @(negedge clk);
    chk("single_after_valid", 32'(bus8.o_valid), 32'd0);
    chk("single_after_ack", 32'(bus8.ack), 32'd0);

    // Round-robin fairness from a fresh pointer.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus8.req = 8'hFF;
    for (int i = 0; i < 16; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      sb8.push_back(mk(0, 1));
`else
      sb8.push_back(mk(i % 8, (i % 8) + 1));
`endif
    end
    drain("rr");
    bus8.req = '0;

    // Backpressure with data changing underneath.
    bus8.req = 8'b0000_1000;
    bus8.o_ready = 1'b0;
    sb8.push_back(mk(3, 4));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus8.data[3*16 +: 16] = 16'hBEEF;
      @(negedge clk);
      chk("bp_o", 32'(bus8.o), 32'd4);
      chk("bp_valid", 32'(bus8.o_valid), 32'd1);
      chk("bp_ack", 32'(bus8.ack), 32'd0);
    end
    @(posedge clk); #1;
    bus8.o_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_o", 32'(bus8.o), 32'd4);
    chk("bp_hs_ack", 32'(bus8.ack), 32'h08);
    @(posedge clk); #1;
    bus8.req = '0;
    bus8.data[3*16 +: 16] = 16'd4;
    drain("bp");

    // Rotation wrap: last grant 6, then requesters 6 and 1.
    bus8.req = 8'b0100_0000;
    sb8.push_back(mk(6, 7));
    drain("rot_six");
    bus8.req = 8'b0100_0010;
    sb8.push_back(mk(1, 2));
    drain("rot_wrap");
    bus8.req = 8'b0100_0000;
    sb8.push_back(mk(6, 7));
    drain("rot_rest");

    // After a grant to 0, requesters 7 and 0 compete.
    bus8.req = 8'b0000_0001;
    sb8.push_back(mk(0, 1));
    drain("prio_zero");
    bus8.req = 8'b1000_0001;
`ifdef ARB_FIXED_PRIO_EN
    sb8.push_back(mk(0, 1));
    drain("prio_first");
    bus8.req = 8'b1000_0000;
    sb8.push_back(mk(7, 8));
`else
    sb8.push_back(mk(7, 8));
    drain("prio_first");
    bus8.req = 8'b0000_0001;
    sb8.push_back(mk(0, 1));
`endif
    drain("prio_second");
    bus8.req = '0;

    // Four-requester instance.
    bus4.req = 4'hF;
    bus4.o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      sb4.push_back(mk(0, 1));
`else
      sb4.push_back(mk(i % 4, (i % 4) + 1));
`endif
    end
    drain("n4");
    bus4.req = '0;
    @(negedge clk);
    chk("n4_quiet_ack", 32'(bus4.ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
